// File: rtl/saturn_bus_master.sv
// saturn_bus_master
//   Initiator side of the HP48 nibble bus. Turns one core transfer request
//   (read or write of 1..16 nibbles starting at a 20-bit address) into a
//   sequence of strobed bus cycles toward hp48_bus. Read nibbles and the bus
//   error flag are collected and returned as a packed 64-bit result together
//   with a one-cycle done pulse.
//
// Ports
//   clk            : system clock, rising edge
//   reset          : asynchronous reset, active low
//   req_valid      : transfer request valid
//   req_ready      : master idle, request accepted this cycle
//   req_write      : 1 = write, 0 = read
//   req_use_pc     : read through PC instead of DP (ignored for writes)
//   req_addr       : address of the first nibble
//   req_count      : nibble count minus one
//   req_wdata      : write data, nibble k at [4k+3:4k]
//   busy           : transfer in progress
//   done           : one-cycle end-of-transfer pulse
//   err            : valid with done, bus error aborted the transfer
//   rdata          : read data, unread nibbles zero, held until next accept
//   bus_strobe     : one strobe per nibble transferred
//   bus_address    : nibble address of the current bus cycle
//   bus_command    : bus command code
//   bus_nibble_out : write nibble toward the bus
//   bus_nibble_in  : read nibble from the bus
//   bus_error      : bus error from the bus
module saturn_bus_master #(
  parameter int unsigned READ_LATENCY = 1  // 1..4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_use_pc,
  input  logic [19:0] req_addr,
  input  logic [3:0]  req_count,
  input  logic [63:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [63:0] rdata,
  output logic        bus_strobe,
  output logic [19:0] bus_address,
  output logic [3:0]  bus_command,
  output logic [3:0]  bus_nibble_out,
  input  logic [3:0]  bus_nibble_in,
  input  logic        bus_error
);

  // Bus command codes shared with hp48_bus.
  localparam logic [3:0] BUSCMD_NOP      = 4'h0;
  localparam logic [3:0] BUSCMD_PC_READ  = 4'h1;
  localparam logic [3:0] BUSCMD_DP_READ  = 4'h2;
  localparam logic [3:0] BUSCMD_DP_WRITE = 4'h3;

  localparam logic [1:0] LAST_WAIT = 2'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STROBE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t      state, state_next;
  logic [3:0]  k, k_next;
  logic [1:0]  wcnt;
  logic [19:0] addr_q;
  logic [3:0]  count_q;
  logic        write_q;
  logic        use_pc_q;
  logic [63:0] wdata_q;

  logic        accept;
  logic        err_hit;
  logic        capture;

  // Selected transfer parameters: on the accept cycle the latches are not
  // yet loaded, so the request inputs are used directly.
  logic [19:0] sel_addr;
  logic        sel_write;
  logic        sel_use_pc;
  logic [63:0] sel_wdata;
  logic [19:0] strobe_addr;
  logic [3:0]  strobe_cmd;
  logic [3:0]  strobe_nib;

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state == ST_STROBE) || (state == ST_WAIT);

  always_comb begin
    state_next = state;
    k_next     = k;
    accept     = 1'b0;
    err_hit    = 1'b0;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          k_next     = '0;
          state_next = ST_STROBE;
        end
      end
      ST_STROBE: begin
        if (bus_error) begin
          err_hit    = 1'b1;
          state_next = ST_DONE;
        end else if (write_q) begin
          if (k == count_q) begin
            state_next = ST_DONE;
          end else begin
            k_next = k + 4'd1;
          end
        end else begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wcnt == LAST_WAIT) begin
          capture = 1'b1;
          if (k == count_q) begin
            state_next = ST_DONE;
          end else begin
            k_next     = k + 4'd1;
            state_next = ST_STROBE;
          end
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Bus outputs are registered, so they are computed from the next state
  // and next nibble index rather than the current ones.
  always_comb begin
    sel_addr    = accept ? req_addr   : addr_q;
    sel_write   = accept ? req_write  : write_q;
    sel_use_pc  = accept ? req_use_pc : use_pc_q;
    sel_wdata   = accept ? req_wdata  : wdata_q;
    strobe_addr = sel_addr + {16'd0, k_next};
    if (sel_write) begin
      strobe_cmd = BUSCMD_DP_WRITE;
      strobe_nib = sel_wdata[{k_next, 2'b00} +: 4];
    end else begin
      strobe_cmd = sel_use_pc ? BUSCMD_PC_READ : BUSCMD_DP_READ;
      strobe_nib = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      k              <= '0;
      wcnt           <= '0;
      addr_q         <= '0;
      count_q        <= '0;
      write_q        <= 1'b0;
      use_pc_q       <= 1'b0;
      wdata_q        <= '0;
      done           <= 1'b0;
      err            <= 1'b0;
      rdata          <= '0;
      bus_strobe     <= 1'b0;
      bus_address    <= '0;
      bus_command    <= BUSCMD_NOP;
      bus_nibble_out <= '0;
    end else begin
      state <= state_next;
      k     <= k_next;
      wcnt  <= (state == ST_WAIT && state_next == ST_WAIT) ? wcnt + 2'd1 : '0;

      if (accept) begin
        addr_q   <= req_addr;
        count_q  <= req_count;
        write_q  <= req_write;
        use_pc_q <= req_use_pc;
        wdata_q  <= req_wdata;
        rdata    <= '0;
        err      <= 1'b0;
      end
      if (err_hit) begin
        err <= 1'b1;
      end
      if (capture) begin
        rdata[{k, 2'b00} +: 4] <= bus_nibble_in;
      end

      done       <= (state_next == ST_DONE);
      bus_strobe <= (state_next == ST_STROBE);

      case (state_next)
        ST_STROBE: begin
          bus_address    <= strobe_addr;
          bus_command    <= strobe_cmd;
          bus_nibble_out <= strobe_nib;
        end
        ST_WAIT: begin
          // address, command and nibble held for the read latency
        end
        default: begin
          bus_command    <= BUSCMD_NOP;
          bus_nibble_out <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_saturn_bus_master.sv
// tb_saturn_bus_master
//   Bench for saturn_bus_master. A nibble memory answers bus cycles; each
//   transfer is expanded into a per-cycle expected output trace from the
//   transfer rules (strobe per nibble, read latency, DONE cycle), and one
//   process compares the DUT against that trace every cycle.
module tb_saturn_bus_master;

  localparam int L = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_use_pc = 1'b0;
  logic [19:0] req_addr = '0;
  logic [3:0]  req_count = '0;
  logic [63:0] req_wdata = '0;
  logic        busy;
  logic        done;
  logic        err;
  logic [63:0] rdata;
  logic        bus_strobe;
  logic [19:0] bus_address;
  logic [3:0]  bus_command;
  logic [3:0]  bus_nibble_out;
  logic [3:0]  bus_nibble_in = '0;
  logic        bus_error = 1'b0;

  saturn_bus_master #(.READ_LATENCY(L)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_use_pc     (req_use_pc),
    .req_addr       (req_addr),
    .req_count      (req_count),
    .req_wdata      (req_wdata),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .rdata          (rdata),
    .bus_strobe     (bus_strobe),
    .bus_address    (bus_address),
    .bus_command    (bus_command),
    .bus_nibble_out (bus_nibble_out),
    .bus_nibble_in  (bus_nibble_in),
    .bus_error      (bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        strobe;
    logic [19:0] addr;
    logic [3:0]  cmd;
    logic [3:0]  nib;
    logic        busy;
    logic        ready;
    logic        done;
    logic        err;
    logic [63:0] rd;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        ce;
  int          nvec = 0;
  int          nfail = 0;
  logic [3:0]  mem[logic [19:0]];
  int          scount = 0;
  int          err_at = -1;
  logic [19:0] last_addr = '0;

  // Unwritten locations read as (address low nibble + 2).
  function automatic logic [3:0] memrd(logic [19:0] a);
    if (mem.exists(a)) return mem[a];
    return a[3:0] + 4'd2;
  endfunction

  // Bus slave: writes land at the strobe edge; read nibbles and the error
  // flag are presented from the falling edge so they are stable at capture.
  always @(posedge clk) begin
    if (req_valid && req_ready) begin
      scount = 0;
    end else if (bus_strobe) begin
      if (bus_command == 4'h3 && !bus_error) mem[bus_address] = bus_nibble_out;
      scount = scount + 1;
    end
  end

  always @(negedge clk) begin
    bus_nibble_in = (bus_command == 4'h1 || bus_command == 4'h2) ? memrd(bus_address) : 4'h0;
    bus_error     = bus_strobe && (scount == err_at);
  end

  function automatic void push_e(logic s, logic [19:0] a, logic [3:0] c, logic [3:0] n,
                                 logic b, logic r, logic d, logic e, logic [63:0] rd);
    exp_t x;
    x.strobe = s; x.addr = a; x.cmd = c; x.nib = n;
    x.busy = b; x.ready = r; x.done = d; x.err = e; x.rd = rd;
    exp_q.push_back(x);
  endfunction

  // Expected cycles following the accept edge of one transfer.
  function automatic void build(logic w, logic pc, logic [19:0] a, logic [3:0] cnt,
                                logic [63:0] wd, int eat);
    logic [63:0] rd;
    logic        erred;
    logic [3:0]  c;
    logic [19:0] ai;
    logic [3:0]  n;
    rd    = '0;
    erred = 1'b0;
    c     = w ? 4'h3 : (pc ? 4'h1 : 4'h2);
    for (int i = 0; i <= int'(cnt); i++) begin
      ai        = a + 20'(i);
      last_addr = ai;
      n         = w ? 4'((wd >> (4 * i)) & 64'hf) : 4'h0;
      push_e(1'b1, ai, c, n, 1'b1, 1'b0, 1'b0, 1'b0, '0);
      if (i == eat) begin
        erred = 1'b1;
        break;
      end
      if (!w) begin
        for (int j = 0; j < L; j++) push_e(1'b0, ai, c, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        rd = rd | (64'(memrd(ai)) << (4 * i));
      end
    end
    push_e(1'b0, last_addr, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, erred, rd);
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    nvec++;
    if (exp_q.size() > 0) begin
      ce = exp_q.pop_front();
      if (bus_strobe !== ce.strobe || bus_address !== ce.addr || bus_command !== ce.cmd ||
          bus_nibble_out !== ce.nib || busy !== ce.busy || req_ready !== ce.ready ||
          done !== ce.done || (ce.done && (err !== ce.err || rdata !== ce.rd))) begin
        nfail++;
        $display("FAIL trace t=%0t: got strb=%b addr=%h cmd=%h nib=%h busy=%b rdy=%b done=%b err=%b rdata=%h; required strb=%b addr=%h cmd=%h nib=%h busy=%b rdy=%b done=%b err=%b rdata=%h",
                 $time, bus_strobe, bus_address, bus_command, bus_nibble_out, busy, req_ready,
                 done, err, rdata, ce.strobe, ce.addr, ce.cmd, ce.nib, ce.busy, ce.ready,
                 ce.done, ce.err, ce.rd);
      end
    end else if (bus_strobe !== 1'b0 || bus_command !== 4'h0 || busy !== 1'b0 ||
                 req_ready !== 1'b1 || done !== 1'b0 || bus_nibble_out !== 4'h0) begin
      nfail++;
      $display("FAIL idle t=%0t: got strb=%b cmd=%h nib=%h busy=%b rdy=%b done=%b; required 0 0 0 0 1 0",
               $time, bus_strobe, bus_command, bus_nibble_out, busy, req_ready, done);
    end
  end

  task automatic check64(string nm, logic [63:0] got, logic [63:0] want);
    nvec++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %h required %h", nm, got, want);
    end
  endtask

  task automatic wait_done(string nm);
    int t;
    t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (done !== 1'b1 && t < 200);
    nvec++;
    if (done !== 1'b1) begin
      nfail++;
      $display("FAIL %s timeout: done=%b required 1", nm, done);
    end
    @(negedge clk);
  endtask

  task automatic do_xfer(string nm, logic w, logic pc, logic [19:0] a, logic [3:0] cnt,
                         logic [63:0] wd);
    @(negedge clk);
    req_write  = w;
    req_use_pc = pc;
    req_addr   = a;
    req_count  = cnt;
    req_wdata  = wd;
    req_valid  = 1'b1;
    build(w, pc, a, cnt, wd, err_at);
    @(negedge clk);
    req_valid  = 1'b0;
    // garbage on the request inputs must not disturb the running transfer
    req_write  = ~w;
    req_use_pc = ~pc;
    req_addr   = 20'hABCDE;
    req_count  = 4'hF;
    req_wdata  = 64'hDEAD_BEEF_0BAD_F00D;
    wait_done(nm);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check64("reset rdata", rdata, 64'h0);
    check64("reset address", 64'(bus_address), 64'h0);
    check64("reset ready", 64'(req_ready), 64'h1);
    reset = 1'b1;

    // 1: single PC read of ROM nibble 2
    do_xfer("t1", 1'b0, 1'b1, 20'h00000, 4'd0, '0);
    check64("t1 rdata", rdata, 64'h2);
    check64("t1 err", 64'(err), 64'h0);

    // 2: write four nibbles then read them back
    do_xfer("t2w", 1'b1, 1'b0, 20'h00100, 4'd3, 64'h4321);
    do_xfer("t2r", 1'b0, 1'b0, 20'h00100, 4'd3, '0);
    check64("t2 readback", rdata, 64'h4321);

    // 3: address wrap FFFFE, FFFFF, 00000
    do_xfer("t3", 1'b0, 1'b0, 20'hFFFFE, 4'd2, '0);
    check64("t3 wrap rdata", rdata, 64'h210);

    // 4: bus error on the third strobe of a five-nibble read
    err_at = 2;
    do_xfer("t4", 1'b0, 1'b0, 20'h00200, 4'd4, '0);
    check64("t4 rdata", rdata, 64'h32);
    check64("t4 err", 64'(err), 64'h1);
    err_at = -1;

    // 5: reset during the WAIT of a 16-nibble read
    @(negedge clk);
    req_write  = 1'b0;
    req_use_pc = 1'b0;
    req_addr   = 20'h00300;
    req_count  = 4'd15;
    req_valid  = 1'b1;
    build(1'b0, 1'b0, 20'h00300, 4'd15, '0, -1);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check64("t5 in wait", {62'd0, busy, bus_strobe}, 64'h2);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check64("t5 reset outputs", {52'd0, bus_strobe, bus_command, done, req_ready, 5'd0}, 64'h20);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check64("t5 ready after release", 64'(req_ready), 64'h1);
    do_xfer("t5 after", 1'b0, 1'b0, 20'h00005, 4'd0, '0);
    check64("t5 rdata", rdata, 64'h7);

    // 6: req_valid held high across two requests
    @(negedge clk);
    req_write  = 1'b0;
    req_use_pc = 1'b0;
    req_addr   = 20'h00010;
    req_count  = 4'd0;
    req_valid  = 1'b1;
    build(1'b0, 1'b0, 20'h00010, 4'd0, '0, -1);
    push_e(1'b0, last_addr, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    build(1'b1, 1'b0, 20'h00020, 4'd1, 64'hA5, -1);
    @(negedge clk);
    req_write = 1'b1;
    req_addr  = 20'h00020;
    req_count = 4'd1;
    req_wdata = 64'hA5;
    wait_done("t6a");
    @(negedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    wait_done("t6b");
    check64("t6 mem 20", 64'(memrd(20'h00020)), 64'h5);
    check64("t6 mem 21", 64'(memrd(20'h00021)), 64'hA);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
